// File: rtl/axim_pkg.sv
// Shared definitions for the AXI-lite write master and the slaves it talks to.
package axim_pkg;

  // Master sequencing states
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StSend     = 2'd1,
    StWaitResp = 2'd2
  } axim_state_e;

  // AXI write response encoding
  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_EXOKAY = 2'b01;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  // Slave-side signals returned to the master on the AW/W/B channels
  typedef struct packed {
    logic      awready;
    logic      wready;
    logic      bvalid;
    axi_resp_t bresp;
  } axim_slv_rsp_t;

endpackage

// File: rtl/axim_wr_master.sv
// Single-beat AXI-lite write master: takes one command, drives AW and W
// independently, then waits (bounded) for the B response.
module axim_wr_master
  import axim_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_data,
  output logic [ADDRESS_WIDTH-1:0] m_axi_awaddr,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [DATA_WIDTH-1:0]    m_axi_wdata,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic                     done,
  output logic [1:0]               resp,
  output logic                     timeout,
  output logic                     busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  axim_state_e            state_q, state_d;
  logic                   aw_done_q, w_done_q;
  logic                   awvalid_q, wvalid_q;
  logic [ADDRESS_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [CntW-1:0]        cnt_q;
  logic                   done_q, timeout_q;
  axi_resp_t              resp_q;

  logic aw_hs, w_hs, aw_all, w_all, b_hs, cnt_hit;

  // A channel counts as complete if it finished earlier or handshakes now
  assign aw_hs   = awvalid_q & m_axi_awready;
  assign w_hs    = wvalid_q & m_axi_wready;
  assign aw_all  = aw_done_q | aw_hs;
  assign w_all   = w_done_q | w_hs;
  assign b_hs    = (state_q == StWaitResp) & m_axi_bvalid;
  assign cnt_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (cmd_valid) state_d = StSend;
      StSend:     if (aw_all && w_all) state_d = StWaitResp;
      StWaitResp: if (m_axi_bvalid || cnt_hit) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready    = (state_q == StIdle);
    m_axi_bready = (state_q == StWaitResp);
    busy         = (state_q != StIdle);
  end

  // Command capture, per-channel valids/flags, response timer and result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      resp_q    <= RESP_OKAY;
      timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            awaddr_q  <= cmd_addr;
            wdata_q   <= cmd_data;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        StSend: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_all && w_all) cnt_q <= '0;
        end
        StWaitResp: begin
          cnt_q <= cnt_q + CntW'(1);
          // A response arriving on the timeout cycle takes priority
          if (b_hs) begin
            resp_q    <= m_axi_bresp;
            timeout_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (cnt_hit) begin
            resp_q    <= RESP_SLVERR;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign done          = done_q;
  assign resp          = resp_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_axim_wr_master.sv
// Self-checking bench for axim_wr_master: directed corner cases followed by
// randomized back-to-back writes against a cycle-level slave/reference model.
module tb_axim_wr_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned T  = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [AW-1:0] m_axi_awaddr;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;
  logic          done;
  logic [1:0]    resp;
  logic          timeout;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;
  int n_done      = 0;
  int exp_done    = 0;
  logic [1:0] last_resp = 2'b00;
  logic       last_to   = 1'b0;

  axim_wr_master #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .done         (done),
    .resp         (resp),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Count done pulses independently of the per-transaction checks
  always @(negedge clk) if (done === 1'b1) n_done++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one write; entered and left on a negedge. On exit the DUT is in the
  // done cycle (IDLE), so the next call issues its command back-to-back.
  task automatic run_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int aw_dly, input int w_dly, input int b_dly,
                         input logic [1:0] br);
    bit aw_hs = 0, w_hs = 0, aw_now, w_now, got_b = 0;
    int c = 0;
    logic [1:0] exp_resp;
    logic       exp_to;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_data  = data;
    @(negedge clk);
    // Address/data phase: each valid drops the cycle after its own handshake
    while (!(aw_hs && w_hs) && c < 40) begin
      check("awvalid", m_axi_awvalid, !aw_hs);
      check("wvalid", m_axi_wvalid, !w_hs);
      if (!aw_hs) check("awaddr", m_axi_awaddr, addr);
      if (!w_hs) check("wdata", m_axi_wdata, data);
      check("bready_send", m_axi_bready, 0);
      check("busy_send", busy, 1);
      check("cmd_ready_send", cmd_ready, 0);
      check("done_send", done, 0);
      check("resp_hold", {timeout, resp}, {last_to, last_resp});
      m_axi_awready = (c >= aw_dly);
      m_axi_wready  = (c >= w_dly);
      aw_now = m_axi_awvalid && m_axi_awready;
      w_now  = m_axi_wvalid && m_axi_wready;
      cmd_valid = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_data  = $urandom;
      @(negedge clk);
      aw_hs |= aw_now;
      w_hs  |= w_now;
      c++;
    end
    if (!(aw_hs && w_hs)) check("send_bound", 0, 1);
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    // Response phase
    for (int k = 0; k < int'(T); k++) begin
      check("bready_wait", m_axi_bready, 1);
      check("valids_wait", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
      check("done_wait", done, 0);
      m_axi_bvalid = (k >= b_dly);
      m_axi_bresp  = br;
      got_b = m_axi_bvalid;
      cmd_valid = 1'($urandom);
      @(negedge clk);
      if (got_b) break;
    end
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    cmd_valid    = 1'b0;
    exp_resp = (b_dly <= int'(T) - 1) ? br : 2'b10;
    exp_to   = (b_dly > int'(T) - 1);
    exp_done++;
    check("done_pulse", done, 1);
    check("resp", resp, exp_resp);
    check("timeout", timeout, exp_to);
    check("busy_done", busy, 0);
    check("bready_done", m_axi_bready, 0);
    last_resp = exp_resp;
    last_to   = exp_to;
  endtask

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
    m_axi_awready = 1'b0;
    m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'b00;
    #12;
    check("rst_outs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, done, resp, timeout, busy},
          8'h00);
    check("rst_bus", {m_axi_awaddr, m_axi_wdata}, 64'h0);
    check("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    run_txn(32'h0, 32'hDEADBEEF, 0, 0, 1, 2'b00);  // basic write
    run_txn(32'h10, 32'hA5A5A5A5, 3, 0, 0, 2'b00); // skewed AW
    run_txn(32'h4, 32'h00000004, 0, 0, 2, 2'b10);  // error response
    run_txn(32'h8, 32'h0BADF00D, 0, 0, 100, 2'b00); // timeout
    run_txn(32'hC, 32'h11111111, 1, 2, T - 1, 2'b01); // response on timeout cycle
    run_txn(32'h14, 32'h22222222, 0, 4, 0, 2'b00); // skewed W

    // Reset in SEND with awvalid high
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h40;
    cmd_data  = 32'h99;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pre_rst_awvalid", m_axi_awvalid, 1);
    rstn = 1'b0;
    #1;
    check("rst_mid_valids", {m_axi_awvalid, m_axi_wvalid, busy, done}, 4'b0000);
    check("rst_mid_result", {resp, timeout}, 3'b000);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    last_resp = 2'b00;
    last_to   = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_txn(32'h0, 32'h12345678, 0, 0, 0, 2'b00);

    // Randomized back-to-back traffic
    for (int i = 0; i < 40; i++) begin
      run_txn($urandom, $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 10)), 2'($urandom));
    end

    @(negedge clk);
    check("idle_no_done", done, 0);
    check("done_count", n_done, exp_done);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
